// File: rtl/ram_e_dual_port.sv
// ram_e_dual_port: true dual-port synchronous RAM with a zero-fill sweep after reset.
// Port A and port B share one clock. Both ports can read and write.
// Read data is registered. A port that writes returns its own new data on the same cycle.
// A port that reads an address the other port writes in the same cycle gets the old word.
// If both ports write the same address, port A's data is stored and both ports return it.
// Optional macro RAM_E_OUTREG_EN adds a second output register stage (read latency 2).
module ram_e_dual_port #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              collide_c;

  assign collide_c = wea && web && (addra == addrb);

  // Sweep pointer: walks every word once, then raises init_done until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (&clr_ptr) init_done <= 1'b1;
    end
  end

  // Storage: zero-fill while sweeping, then user writes. Port A wins on an address collision.
  // The pointer is held at 0 during reset, so the only word this can touch then is word 0.
  // Word 0 is also the first word the sweep clears.
  always_ff @(posedge clk) begin
    if (!init_done) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (wea) mem[addra] <= dina;
      if (web && !collide_c) mem[addrb] <= dinb;
    end
  end

  // First read stage: write-first on the port's own write. Old data for a cross-port read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (!init_done) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= wea ? dina : mem[addra];
      if (web) rd_b <= collide_c ? dina : dinb;
      else     rd_b <= mem[addrb];
    end
  end

`ifdef RAM_E_OUTREG_EN
  // Second output stage: delays the first stage by one cycle. Holds 0 until the sweep is done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta <= '0;
      doutb <= '0;
    end else if (!init_done) begin
      douta <= '0;
      doutb <= '0;
    end else begin
      douta <= rd_a;
      doutb <= rd_b;
    end
  end
`else
  assign douta = rd_a;
  assign doutb = rd_b;
`endif

endmodule

// File: tb/tb_ram_e_dual_port.sv
// Directed testbench for ram_e_dual_port.
// The expected read latency follows RAM_E_OUTREG_EN in the same way the design does.
module tb_ram_e_dual_port;

`ifdef RAM_E_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        wea, web;
  logic [8:0]  addra, addrb;
  logic [15:0] dina, dinb;
  logic [15:0] douta, doutb;
  logic        init_done;

  int n_checks = 0;
  int n_fail   = 0;

  ram_e_dual_port #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wea = 1'b0; web = 1'b0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    tick(3);
    n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL rst_douta: got %h expected 0000", douta); end
    n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL rst_doutb: got %h expected 0000", doutb); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
  endtask

  task automatic test_sweep;
    logic exp_done;
    rst_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      addrb = 9'(k - 1);
      if (k == 200) begin wea = 1'b1; addra = 9'h005; dina = 16'hBEEF; end
      else wea = 1'b0;
      tick(1);
      exp_done = (k == 512);
      n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL sweep_doutb edge %0d: got %h expected 0000", k, doutb); end
      n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL sweep_douta edge %0d: got %h expected 0000", k, douta); end
      n_checks++; if (init_done !== exp_done) begin n_fail++; $display("FAIL sweep_init_done edge %0d: got %b expected %b", k, init_done, exp_done); end
    end
    wea = 1'b0;
    for (int a = 0; a < 512 + L - 1; a++) begin
      if (a < 512) addrb = 9'(a);
      tick(1);
      if (a >= L - 1) begin
        n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL clear_doutb addr %0d: got %h expected 0000", a - (L - 1), doutb); end
      end
    end
    addra = 9'h005;
    tick(L);
    n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL ignored_write_a5: got %h expected 0000", douta); end
  endtask

  task automatic test_write_read;
    wea = 1'b1; addra = 9'h010; dina = 16'h1234;
    tick(1);
    wea = 1'b0; addra = 9'h000;
    tick(L - 1);
    n_checks++; if (douta !== 16'h1234) begin n_fail++; $display("FAIL wr_douta_write_first: got %h expected 1234", douta); end
    addrb = 9'h010;
    tick(L - 1);
    n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL rd_doutb_early: got %h expected 0000", doutb); end
    tick(1);
    n_checks++; if (doutb !== 16'h1234) begin n_fail++; $display("FAIL rd_doutb: got %h expected 1234", doutb); end
  endtask

  task automatic test_cross_port;
    wea = 1'b1; addra = 9'h020; dina = 16'hAAAA; addrb = 9'h020;
    tick(1);
    wea = 1'b0; addra = 9'h000;
    tick(L - 1);
    n_checks++; if (douta !== 16'hAAAA) begin n_fail++; $display("FAIL xa_douta: got %h expected aaaa", douta); end
    n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL xa_doutb_old: got %h expected 0000", doutb); end
    tick(1);
    n_checks++; if (doutb !== 16'hAAAA) begin n_fail++; $display("FAIL xa_doutb_new: got %h expected aaaa", doutb); end
    web = 1'b1; addrb = 9'h022; dinb = 16'h5A5A; addra = 9'h022;
    tick(1);
    web = 1'b0; addrb = 9'h000;
    tick(L - 1);
    n_checks++; if (doutb !== 16'h5A5A) begin n_fail++; $display("FAIL xb_doutb: got %h expected 5a5a", doutb); end
    n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL xb_douta_old: got %h expected 0000", douta); end
    tick(1);
    n_checks++; if (douta !== 16'h5A5A) begin n_fail++; $display("FAIL xb_douta_new: got %h expected 5a5a", douta); end
  endtask

  task automatic test_collision;
    wea = 1'b1; web = 1'b1; addra = 9'h1FF; addrb = 9'h1FF;
    dina = 16'h1111; dinb = 16'h2222;
    tick(1);
    wea = 1'b0; web = 1'b0;
    tick(L - 1);
    n_checks++; if (douta !== 16'h1111) begin n_fail++; $display("FAIL col_douta: got %h expected 1111", douta); end
    n_checks++; if (doutb !== 16'h1111) begin n_fail++; $display("FAIL col_doutb: got %h expected 1111", doutb); end
    tick(1);
    n_checks++; if (douta !== 16'h1111) begin n_fail++; $display("FAIL col_rd_a: got %h expected 1111", douta); end
    n_checks++; if (doutb !== 16'h1111) begin n_fail++; $display("FAIL col_rd_b: got %h expected 1111", doutb); end
  endtask

  task automatic test_diff_addr;
    wea = 1'b1; web = 1'b1; addra = 9'h030; addrb = 9'h031;
    dina = 16'h5555; dinb = 16'h6666;
    tick(1);
    wea = 1'b0; web = 1'b0; addra = 9'h031; addrb = 9'h030;
    tick(L - 1);
    n_checks++; if (douta !== 16'h5555) begin n_fail++; $display("FAIL diff_douta: got %h expected 5555", douta); end
    n_checks++; if (doutb !== 16'h6666) begin n_fail++; $display("FAIL diff_doutb: got %h expected 6666", doutb); end
    tick(1);
    n_checks++; if (douta !== 16'h6666) begin n_fail++; $display("FAIL diff_rd_a: got %h expected 6666", douta); end
    n_checks++; if (doutb !== 16'h5555) begin n_fail++; $display("FAIL diff_rd_b: got %h expected 5555", doutb); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      wea = 1'b1; addra = 9'h040 + 9'(i); dina = 16'hC000 + 16'(i);
      tick(1);
    end
    wea = 1'b0;
    for (int i = 0; i < 4 + L - 1; i++) begin
      if (i < 4) addrb = 9'h040 + 9'(i);
      tick(1);
      if (i >= L - 1) begin
        n_checks++;
        if (doutb !== 16'hC000 + 16'(i - (L - 1))) begin
          n_fail++; $display("FAIL b2b_doutb %0d: got %h expected %h", i, doutb, 16'hC000 + 16'(i - (L - 1)));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    addra = 9'h010;
    tick(L);
    n_checks++; if (douta !== 16'h1234) begin n_fail++; $display("FAIL pre_rst_douta: got %h expected 1234", douta); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL async_rst_douta: got %h expected 0000", douta); end
    n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL async_rst_doutb: got %h expected 0000", doutb); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL async_rst_init_done: got %b expected 0", init_done); end
    tick(2);
    rst_n = 1'b1;
    tick(100);
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_init_done: got %b expected 0", init_done); end
    #2 rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 600) begin
      tick(1);
      n++;
    end
    n_checks++; if (n != 512) begin n_fail++; $display("FAIL resweep_edges: got %0d expected 512", n); end
    addra = 9'h010; addrb = 9'h1FF;
    tick(L);
    n_checks++; if (douta !== 16'h0000) begin n_fail++; $display("FAIL resweep_clear_a: got %h expected 0000", douta); end
    n_checks++; if (doutb !== 16'h0000) begin n_fail++; $display("FAIL resweep_clear_b: got %h expected 0000", doutb); end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_write_read;
    test_cross_port;
    test_collision;
    test_diff_addr;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
